sig16b_i2s_tx: RTL and testbench

SIG16B_I2S_TX -- requirements
Module: sig16b_i2s_tx

---
 rtl/sig16b_i2s_tx.sv | 145 ++++++++++++++
 tb/tb_sig16b_i2s_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sig16b_i2s_tx.sv
// sig16b_i2s_tx: mono I2S-style transmitter for sign-magnitude 16-bit samples.
// Samples are buffered in a small FIFO, converted to two's complement when a
// frame starts, and sent MSB first in both the left and the right slot.
// Optional feature macro: SIG16B_TX_UNDERFLOW_HOLD_EN -- when defined, an
// underflow frame repeats the last converted word instead of sending zero.
module sig16b_i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sig16b,
    input  logic        sig16b_valid,
    output logic        sig16b_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underflow
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [4:0]       bit_cnt_next;
    logic [15:0]      shift_reg;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             bclk_fall;
    logic             frame_start;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [15:0]      head_word;
    logic [15:0]      uf_word;
    logic [15:0]      frame_word;

    // Sign-magnitude to two's complement; negative zero naturally maps to 0.
    function automatic logic [15:0] to_twos(input logic [15:0] s);
        logic [15:0] mag;
        mag = {1'b0, s[14:0]};
        if (s[15]) begin
            return 16'h0000 - mag;
        end
        return mag;
    endfunction

    assign bclk_fall    = bclk && (div_cnt == DIV_LAST);
    assign bit_cnt_next = bit_cnt + 5'd1;
    assign frame_start  = bclk_fall && (bit_cnt == 5'd31);
    assign fifo_empty   = (count == '0);
    assign sig16b_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign push         = sig16b_valid && sig16b_ready;
    assign pop          = frame_start && !fifo_empty;
    assign head_word    = to_twos(mem[rd_ptr]);
    assign frame_word   = pop ? head_word : uf_word;

`ifdef SIG16B_TX_UNDERFLOW_HOLD_EN
    logic [15:0] last_word;

    // Remember the most recent converted word so an underflow frame can repeat it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_word <= 16'h0000;
        end else if (pop) begin
            last_word <= head_word;
        end
    end

    assign uf_word = last_word;
`else
    assign uf_word = 16'h0000;
`endif

    // Bit clock divider: bclk flips every BCLK_DIV clk cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Serializer: advances one slot bit per bclk falling edge, loading a new word at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 5'd31;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            shift_reg <= 16'h0000;
            underflow <= 1'b0;
        end else begin
            underflow <= frame_start && fifo_empty;
            if (bclk_fall) begin
                bit_cnt <= bit_cnt_next;
                lrclk   <= bit_cnt_next[4];
                if (frame_start) begin
                    sdata     <= frame_word[15];
                    shift_reg <= {frame_word[14:0], frame_word[15]};
                end else begin
                    sdata     <= shift_reg[15];
                    shift_reg <= {shift_reg[14:0], shift_reg[15]};
                end
            end
        end
    end

    // FIFO bookkeeping; a simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents only matter once written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sig16b;
        end
    end

endmodule

// File: tb/tb_sig16b_i2s_tx.sv
// tb_sig16b_i2s_tx: randomized scoreboard bench for sig16b_i2s_tx.
// The driver keeps a queue-based model of the sample buffer and frame timing
// and pushes expected frames; a separate monitor decodes the serial stream.
module tb_sig16b_i2s_tx;

    localparam int DIV    = 4;
    localparam int DEPTH  = 4;
    localparam int HALF   = 2 * DIV;
    localparam int PERIOD = 64 * DIV;

    typedef struct packed {
        logic [15:0] word;
        logic        uf;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sig16b = 16'h0000;
    logic        sig16b_valid = 1'b0;
    logic        sig16b_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underflow;

    frame_t      exp_q[$];
    logic [15:0] model_q[$];
    logic [15:0] script_q[$];
    logic [15:0] last_word = 16'h0000;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    sig16b_i2s_tx #(.BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sig16b       (sig16b),
        .sig16b_valid (sig16b_valid),
        .sig16b_ready (sig16b_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underflow    (underflow)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Compare one observed value with the bench's expectation.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Sign-magnitude value as a signed integer, truncated to 16 bits.
    function automatic logic [15:0] conv(input logic [15:0] s);
        int m;
        int v;
        m = int'(s[14:0]);
        v = s[15] ? -m : m;
        return 16'(v);
    endfunction

    // Random sample biased towards the corner encodings.
    function automatic logic [15:0] random_sample();
        case ($urandom_range(7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic bit is_frame_edge(input int e);
        return (e >= HALF) && (((e - HALF) % PERIOD) == 0);
    endfunction

    // Drive n cycles: scripted samples first, otherwise random valid with pct% probability.
    task automatic apply_stimulus(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            bit          v;
            bit          acc;
            bit          model_ready;
            logic [15:0] d;
            frame_t      f;
            @(negedge clk);
            check_output("bclk", 32'(bclk), 32'((edge_n / DIV) % 2));
            model_ready = (model_q.size() < DEPTH);
            check_output("ready", 32'(sig16b_ready), 32'(model_ready));
            if (script_q.size() > 0) begin
                v = 1'b1;
                d = script_q[0];
            end else begin
                v = ($urandom_range(99) < pct);
                d = random_sample();
            end
            sig16b       = d;
            sig16b_valid = v;
            acc          = v && model_ready;
            @(posedge clk);
            edge_n++;
            if (is_frame_edge(edge_n)) begin
                if (model_q.size() > 0) begin
                    f.word    = model_q.pop_front();
                    f.uf      = 1'b0;
                    last_word = f.word;
                end else begin
`ifdef SIG16B_TX_UNDERFLOW_HOLD_EN
                    f.word = last_word;
`else
                    f.word = 16'h0000;
`endif
                    f.uf = 1'b1;
                end
                exp_q.push_back(f);
            end
            if (acc) begin
                model_q.push_back(conv(d));
                if (script_q.size() > 0) begin
                    void'(script_q.pop_front());
                end
            end
        end
    endtask

    // Idle until the next rising clk edge is a frame start.
    task automatic wait_before_start();
        for (int i = 0; i <= PERIOD; i++) begin
            if (is_frame_edge(edge_n + 1)) begin
                break;
            end
            apply_stimulus(1, 0);
        end
    endtask

    // Assert reset mid-cycle, check the outputs clear at once, then release.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst          = 1'b1;
        sig16b_valid = 1'b0;
        #1;
        check_output("reset_outputs", 32'({bclk, lrclk, sdata, underflow, sig16b_ready}), 32'h0);
        model_q.delete();
        exp_q.delete();
        script_q.delete();
        last_word = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
    endtask

    int          idx = 31;
    bit          prev_bclk = 1'b0;
    bit          have_cur = 1'b0;
    frame_t      cur;
    logic [15:0] left_word = 16'h0000;
    logic [15:0] right_word = 16'h0000;

    // Monitor: decode each bclk falling edge and score completed slots against the queue.
    always @(negedge clk) begin
        if (rst) begin
            idx       = 31;
            prev_bclk = 1'b0;
            have_cur  = 1'b0;
        end else begin
            if (prev_bclk && !bclk) begin
                idx = (idx + 1) % 32;
                if (idx == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("[TB] FAIL frame_expected at t=%0t: got a frame start, expected none", $time);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check_output("underflow_start", 32'(underflow), 32'(cur.uf));
                    end
                end else begin
                    check_output("underflow_idle", 32'(underflow), 32'h0);
                end
                if (have_cur) begin
                    check_output("lrclk", 32'(lrclk), 32'((idx / 16) % 2));
                    if (idx < 16) begin
                        left_word[15 - idx] = sdata;
                    end else begin
                        right_word[31 - idx] = sdata;
                    end
                    if (idx == 15) begin
                        check_output("left_word", 32'(left_word), 32'(cur.word));
                    end
                    if (idx == 31) begin
                        check_output("right_word", 32'(right_word), 32'(cur.word));
                    end
                end
            end else begin
                check_output("underflow_idle", 32'(underflow), 32'h0);
            end
            prev_bclk = bclk;
        end
    end

    // Test sequence: directed corner cases followed by a randomized run.
    initial begin
        $display("[TB] starting sig16b_i2s_tx bench");
        do_reset();
        script_q.push_back(16'h8001);
        apply_stimulus(2 * PERIOD, 0);

        do_reset();
        script_q.push_back(16'h7FFF);
        script_q.push_back(16'h8000);
        script_q.push_back(16'h0005);
        apply_stimulus(4 * PERIOD, 0);

        do_reset();
        script_q.push_back(16'h0123);
        apply_stimulus(3 * PERIOD, 0);

        do_reset();
        apply_stimulus(6 * PERIOD, 100);

        do_reset();
        apply_stimulus(PERIOD, 0);
        wait_before_start();
        script_q.push_back(16'h4321);
        apply_stimulus(2 * PERIOD, 0);

        do_reset();
        script_q.push_back(16'h1111);
        script_q.push_back(16'h9222);
        script_q.push_back(16'h3333);
        script_q.push_back(16'hC444);
        apply_stimulus(HALF + 7 * HALF + 1, 0);
        do_reset();
        apply_stimulus(2 * PERIOD, 0);

        do_reset();
        apply_stimulus(12 * PERIOD, 30);
        apply_stimulus(8 * PERIOD, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
